// File: rtl/pll_reconfig_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_reconfig_pkg
// Purpose  : Shared types and constants for the PLL DRP reconfiguration
//            sequencer: state encoding, result codes, DRP step record and
//            the per-set register table.
// Revision : 1.0 - initial release
// ============================================================================
package pll_reconfig_pkg;

  // Sequencer states
  typedef enum logic [3:0] {
    ST_HOLD      = 4'd0,
    ST_RD        = 4'd1,
    ST_RD_WAIT   = 4'd2,
    ST_WR        = 4'd3,
    ST_WR_WAIT   = 4'd4,
    ST_RELEASE   = 4'd5,
    ST_WAIT_LOCK = 4'd6,
    ST_DONE      = 4'd7,
    ST_IDLE      = 4'd8
  } state_t;

  // Result codes reported on ERR
  localparam logic [1:0] c_err_ok   = 2'd0;
  localparam logic [1:0] c_err_drp  = 2'd1;
  localparam logic [1:0] c_err_lock = 2'd2;

  // One read-modify-write step: bits set in mask are replaced by value
  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] value;
  } drp_step_t;

  localparam int c_cfg_steps = 4;

  // CLKOUT0 ClkReg1/ClkReg2 then CLKFBOUT ClkReg1/ClkReg2.
  // ClkReg1 rewrites HIGH_TIME/LOW_TIME, ClkReg2 rewrites EDGE/NO_COUNT.
  // Set 0: CLKOUT0 /10, CLKFBOUT /8.  Set 1: CLKOUT0 /5 (odd, EDGE=1), CLKFBOUT /16.
  localparam drp_step_t PLL_CFG_TABLE [2][c_cfg_steps] = '{
    '{ '{7'h08, 16'h0FFF, 16'h0145},
       '{7'h09, 16'h00C0, 16'h0000},
       '{7'h14, 16'h0FFF, 16'h0104},
       '{7'h15, 16'h00C0, 16'h0000} },
    '{ '{7'h08, 16'h0FFF, 16'h00C2},
       '{7'h09, 16'h00C0, 16'h0080},
       '{7'h14, 16'h0FFF, 16'h0208},
       '{7'h15, 16'h00C0, 16'h0000} }
  };

  // Table lookup; steps beyond the table leave registers untouched
  function automatic drp_step_t cfg_step(input logic sel, input logic [15:0] step);
    if (step < 16'(c_cfg_steps))
      return PLL_CFG_TABLE[sel][step[1:0]];
    else
      return '0;
  endfunction

  // Saturating decrement used to turn a cycle count into a timer load value
  function automatic logic [15:0] sat_dec(input logic [15:0] v);
    return (v == 16'd0) ? 16'd0 : v - 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_reconfig_timer.sv
`default_nettype none
// ============================================================================
// Module   : pll_reconfig_timer
// Purpose  : Loadable 16-bit saturating down-counter; done is high while the
//            count sits at zero. A load of N gives done after N cycles.
// Revision : 1.0 - initial release
// ============================================================================
module pll_reconfig_timer #(
  parameter logic [15:0] RESET_VAL = 16'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        done
);

  logic [15:0] r_count;

  // Load has priority; otherwise count down and stick at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_count <= RESET_VAL;
    else if (load)
      r_count <= load_val;
    else if (r_count != 16'd0)
      r_count <= r_count - 16'd1;
  end

  assign done = (r_count == 16'd0);

endmodule
`default_nettype wire

// File: rtl/pll_reconfig_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pll_reconfig_ctrl
// Purpose  : DRP master that brings the PLL up after reset and services
//            reconfiguration requests (hold reset, read-modify-write the
//            register table, release reset, wait for lock).
// Options  : PLL_RECONFIG_LOCK_MON_EN - lock-loss monitor in IDLE
// Revision : 1.0 - initial release
// ============================================================================
module pll_reconfig_ctrl
  import pll_reconfig_pkg::*;
#(
  parameter int unsigned NUM_STEPS    = 4,
  parameter int unsigned RST_HOLD     = 8,
  parameter int unsigned DRP_TIMEOUT  = 64,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic        DCLK,
  input  logic        RST_N,
  input  logic        REQ,
  input  logic        REQ_SEL,
  output logic        ACK,
  output logic        BUSY,
  output logic [1:0]  ERR,
  output logic        LOCK_LOST,
  output logic        PLL_RST,
  output logic [6:0]  DADDR,
  output logic        DEN,
  output logic        DWE,
  output logic [15:0] DI,
  input  logic [15:0] DO,
  input  logic        DRDY,
  input  logic        LOCKED
);

  // Timer load values: a load of N-1 keeps a state for N cycles
  localparam logic [15:0] c_hold_ld = sat_dec(16'(RST_HOLD));
  localparam logic [15:0] c_drp_ld  = sat_dec(16'(DRP_TIMEOUT));
  localparam logic [15:0] c_lock_ld = sat_dec(16'(LOCK_TIMEOUT));
  localparam logic [15:0] c_last_step = sat_dec(16'(NUM_STEPS));

  state_t      r_state, w_state_nxt;
  logic        r_pll_rst, w_pll_rst_nxt;
  logic [1:0]  r_err, w_err_nxt;
  logic        r_skip_drp, w_skip_nxt;
  logic        r_sel, w_sel_nxt;
  logic [15:0] r_step, w_step_nxt;
  logic [15:0] r_di, w_di_nxt;
  logic [1:0]  r_lock_sync;
  logic        w_locked;
  logic        w_lock_drop;
  logic        w_tmr_load;
  logic [15:0] w_tmr_val;
  logic        w_tmr_done;
  logic        w_drp_active;
  drp_step_t   w_cur;

  assign w_locked = r_lock_sync[1];
  assign w_cur    = cfg_step(r_sel, r_step);

  pll_reconfig_timer #(
    .RESET_VAL (c_hold_ld)
  ) u_timer (
    .clk      (DCLK),
    .rst_n    (RST_N),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .done     (w_tmr_done)
  );

  // Two-flop synchroniser for the asynchronous PLL lock indication
  always_ff @(posedge DCLK or negedge RST_N) begin
    if (!RST_N)
      r_lock_sync <= 2'b00;
    else
      r_lock_sync <= {r_lock_sync[0], LOCKED};
  end

`ifdef PLL_RECONFIG_LOCK_MON_EN
  logic r_lock_d;
  logic r_lock_lost;

  assign w_lock_drop = r_lock_d & ~w_locked;
  assign LOCK_LOST   = r_lock_lost;

  // Edge-detect lock loss and keep a sticky flag once seen while idle
  always_ff @(posedge DCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_lock_d    <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_lock_d <= w_locked;
      if (r_state == ST_IDLE && w_lock_drop)
        r_lock_lost <= 1'b1;
    end
  end
`else
  assign w_lock_drop = 1'b0;
  assign LOCK_LOST   = 1'b0;
`endif

  // State register; reset starts a bring-up-only sequence
  always_ff @(posedge DCLK or negedge RST_N) begin
    if (!RST_N)
      r_state <= ST_HOLD;
    else
      r_state <= w_state_nxt;
  end

  // Next-state logic, timer loads and datapath updates
  always_comb begin
    w_state_nxt   = r_state;
    w_tmr_load    = 1'b0;
    w_tmr_val     = 16'd0;
    w_pll_rst_nxt = r_pll_rst;
    w_err_nxt     = r_err;
    w_skip_nxt    = r_skip_drp;
    w_sel_nxt     = r_sel;
    w_step_nxt    = r_step;
    w_di_nxt      = r_di;
    case (r_state)
      ST_HOLD: begin
        w_pll_rst_nxt = 1'b1;
        if (w_tmr_done) begin
          if (r_skip_drp) begin
            w_state_nxt = ST_RELEASE;
            w_tmr_load  = 1'b1;
            w_tmr_val   = c_hold_ld;
          end else begin
            w_step_nxt  = 16'd0;
            w_state_nxt = ST_RD;
            w_tmr_load  = 1'b1;
            w_tmr_val   = c_drp_ld;
          end
        end
      end
      ST_RD: w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (DRDY) begin
          w_di_nxt    = (DO & ~w_cur.mask) | (w_cur.value & w_cur.mask);
          w_state_nxt = ST_WR;
          w_tmr_load  = 1'b1;
          w_tmr_val   = c_drp_ld;
        end else if (w_tmr_done) begin
          w_err_nxt   = c_err_drp;
          w_state_nxt = ST_DONE;
        end
      end
      ST_WR: w_state_nxt = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (DRDY) begin
          w_tmr_load = 1'b1;
          if (r_step == c_last_step) begin
            w_state_nxt = ST_RELEASE;
            w_tmr_val   = c_hold_ld;
          end else begin
            w_step_nxt  = r_step + 16'd1;
            w_state_nxt = ST_RD;
            w_tmr_val   = c_drp_ld;
          end
        end else if (w_tmr_done) begin
          w_err_nxt   = c_err_drp;
          w_state_nxt = ST_DONE;
        end
      end
      ST_RELEASE: begin
        if (w_tmr_done) begin
          w_pll_rst_nxt = 1'b0;
          w_state_nxt   = ST_WAIT_LOCK;
          w_tmr_load    = 1'b1;
          w_tmr_val     = c_lock_ld;
        end
      end
      ST_WAIT_LOCK: begin
        if (w_locked) begin
          w_err_nxt   = c_err_ok;
          w_state_nxt = ST_DONE;
        end else if (w_tmr_done) begin
          w_err_nxt     = c_err_lock;
          w_pll_rst_nxt = 1'b1;
          w_state_nxt   = ST_DONE;
        end
      end
      ST_DONE: begin
        w_skip_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_lock_drop) begin
          w_skip_nxt    = 1'b1;
          w_pll_rst_nxt = 1'b1;
          w_state_nxt   = ST_HOLD;
          w_tmr_load    = 1'b1;
          w_tmr_val     = c_hold_ld;
        end else if (REQ) begin
          w_sel_nxt     = REQ_SEL;
          w_skip_nxt    = 1'b0;
          w_pll_rst_nxt = 1'b1;
          w_state_nxt   = ST_HOLD;
          w_tmr_load    = 1'b1;
          w_tmr_val     = c_hold_ld;
        end
      end
      default: begin
        w_pll_rst_nxt = 1'b1;
        w_state_nxt   = ST_HOLD;
        w_tmr_load    = 1'b1;
        w_tmr_val     = c_hold_ld;
      end
    endcase
  end

  // Datapath registers; reset leaves the PLL held with the next sequence bring-up only
  always_ff @(posedge DCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pll_rst  <= 1'b1;
      r_err      <= c_err_ok;
      r_skip_drp <= 1'b1;
      r_sel      <= 1'b0;
      r_step     <= 16'd0;
      r_di       <= 16'd0;
    end else begin
      r_pll_rst  <= w_pll_rst_nxt;
      r_err      <= w_err_nxt;
      r_skip_drp <= w_skip_nxt;
      r_sel      <= w_sel_nxt;
      r_step     <= w_step_nxt;
      r_di       <= w_di_nxt;
    end
  end

  // Address and write strobe stay put for the whole access, DEN only pulses
  assign w_drp_active = (r_state == ST_RD) || (r_state == ST_RD_WAIT) ||
                        (r_state == ST_WR) || (r_state == ST_WR_WAIT);
  assign DADDR   = w_drp_active ? w_cur.addr : 7'd0;
  assign DEN     = (r_state == ST_RD) || (r_state == ST_WR);
  assign DWE     = (r_state == ST_WR) || (r_state == ST_WR_WAIT);
  assign DI      = r_di;
  assign PLL_RST = r_pll_rst;
  assign ERR     = r_err;
  assign ACK     = (r_state == ST_DONE);
  assign BUSY    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pll_reconfig_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_reconfig_ctrl
// Purpose  : Self-checking bench for pll_reconfig_ctrl with a DRP responder
//            (DRDY one cycle after DEN) and a PLL lock model (LOCKED 50
//            cycles after PLL_RST falls).
// Options  : PLL_RECONFIG_LOCK_MON_EN - also exercises the lock-loss monitor
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_reconfig_ctrl;

  logic        DCLK;
  logic        RST_N;
  logic        REQ;
  logic        REQ_SEL;
  logic        ACK;
  logic        BUSY;
  logic [1:0]  ERR;
  logic        LOCK_LOST;
  logic        PLL_RST;
  logic [6:0]  DADDR;
  logic        DEN;
  logic        DWE;
  logic [15:0] DI;
  logic [15:0] DO;
  logic        DRDY = 1'b0;
  logic        LOCKED = 1'b0;

  logic        drp_answer;
  logic        lock_block;
  int          lock_cnt = 0;

  int n_chk = 0;
  int n_pass = 0;

  // Sequence observations
  int n_rst_hi, n_den, n_wr, n_rd;
  int first_den, last_wr, rst_fall, lock_rise, ack_at;
  logic [6:0]  wr_addr [8];
  logic [6:0]  rd_addr [8];
  logic [15:0] wr_di   [8];

  typedef struct {
    logic        sel;
    logic [15:0] dov;
    logic [63:0] di;   // {step3, step2, step1, step0}
  } vec_t;

  vec_t       vecs [4];
  logic [6:0] exp_addr [4];

  pll_reconfig_ctrl dut (
    .DCLK      (DCLK),
    .RST_N     (RST_N),
    .REQ       (REQ),
    .REQ_SEL   (REQ_SEL),
    .ACK       (ACK),
    .BUSY      (BUSY),
    .ERR       (ERR),
    .LOCK_LOST (LOCK_LOST),
    .PLL_RST   (PLL_RST),
    .DADDR     (DADDR),
    .DEN       (DEN),
    .DWE       (DWE),
    .DI        (DI),
    .DO        (DO),
    .DRDY      (DRDY),
    .LOCKED    (LOCKED)
  );

  initial DCLK = 1'b0;
  always #5 DCLK = ~DCLK;

  // DRP responder: completion one cycle after each DEN
  always @(posedge DCLK) begin
    if (!RST_N)
      DRDY <= 1'b0;
    else
      DRDY <= DEN && drp_answer;
  end

  // PLL lock model: lock 50 cycles after reset release
  always @(posedge DCLK) begin
    if (PLL_RST || lock_block) begin
      lock_cnt <= 0;
      LOCKED   <= 1'b0;
    end else if (lock_cnt < 49) begin
      lock_cnt <= lock_cnt + 1;
    end else begin
      LOCKED <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  // Watch a sequence from the current negedge until ACK, bounded
  task automatic seq_watch(input int budget);
    n_rst_hi = 0; n_den = 0; n_wr = 0; n_rd = 0;
    first_den = -1; last_wr = -1; rst_fall = -1; lock_rise = -1; ack_at = -1;
    for (int i = 0; i < budget; i++) begin
      if (PLL_RST) n_rst_hi++;
      else if (rst_fall < 0) rst_fall = i;
      if (rst_fall >= 0 && LOCKED && lock_rise < 0) lock_rise = i;
      if (DEN) begin
        n_den++;
        if (first_den < 0) first_den = i;
        if (DWE) begin
          if (n_wr < 8) begin
            wr_addr[n_wr] = DADDR;
            wr_di[n_wr]   = DI;
          end
          n_wr++;
          last_wr = i;
        end else begin
          if (n_rd < 8) rd_addr[n_rd] = DADDR;
          n_rd++;
        end
      end
      if (ACK) begin
        ack_at = i;
        break;
      end
      @(negedge DCLK);
    end
    chk("ack_seen", 32'(ack_at >= 0), 32'd1);
  endtask

  task automatic start_req(input logic sel);
    REQ     = 1'b1;
    REQ_SEL = sel;
    @(negedge DCLK);
    REQ     = 1'b0;
  endtask

  initial begin
    int nw;
    RST_N = 1'b0; REQ = 1'b0; REQ_SEL = 1'b0; DO = 16'hFFFF;
    drp_answer = 1'b1; lock_block = 1'b0;

    exp_addr[0] = 7'h08; exp_addr[1] = 7'h09; exp_addr[2] = 7'h14; exp_addr[3] = 7'h15;
    vecs[0] = '{1'b1, 16'hFFFF, {16'hFF3F, 16'hF208, 16'hFFBF, 16'hF0C2}};
    vecs[1] = '{1'b0, 16'h0000, {16'h0000, 16'h0104, 16'h0000, 16'h0145}};
    vecs[2] = '{1'b0, 16'hA5A5, {16'hA525, 16'hA104, 16'hA525, 16'hA145}};
    vecs[3] = '{1'b1, 16'h5A5A, {16'h5A1A, 16'h5208, 16'h5A9A, 16'h50C2}};

    // Reset values
    repeat (3) @(negedge DCLK);
    chk("rst_pll_rst", 32'(PLL_RST), 32'd1);
    chk("rst_busy", 32'(BUSY), 32'd1);
    chk("rst_ack", 32'(ACK), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_lock_lost", 32'(LOCK_LOST), 32'd0);
    chk("rst_den", 32'(DEN), 32'd0);
    chk("rst_dwe", 32'(DWE), 32'd0);
    chk("rst_daddr", 32'(DADDR), 32'd0);
    chk("rst_di", 32'(DI), 32'd0);

    // Power-up bring-up
    RST_N = 1'b1;
    seq_watch(3000);
    chk("bringup_rst_cycles", 32'(n_rst_hi), 32'd16);
    chk("bringup_den", 32'(n_den), 32'd0);
    chk("bringup_err", 32'(ERR), 32'd0);
    chk("bringup_lock_to_ack", 32'(ack_at - lock_rise), 32'd3);
    @(negedge DCLK);
    chk("bringup_ack_one_cycle", 32'(ACK), 32'd0);
    chk("bringup_busy_low", 32'(BUSY), 32'd0);

    // Reconfiguration vectors
    for (int v = 0; v < 4; v++) begin
      DO = vecs[v].dov;
      start_req(vecs[v].sel);
      seq_watch(3000);
      chk($sformatf("v%0d_n_rd", v), 32'(n_rd), 32'd4);
      chk($sformatf("v%0d_n_wr", v), 32'(n_wr), 32'd4);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("v%0d_rd_addr%0d", v, k), 32'(rd_addr[k]), 32'(exp_addr[k]));
        chk($sformatf("v%0d_wr_addr%0d", v, k), 32'(wr_addr[k]), 32'(exp_addr[k]));
        chk($sformatf("v%0d_wr_di%0d", v, k), 32'(wr_di[k]), 32'(vecs[v].di[16*k +: 16]));
      end
      chk($sformatf("v%0d_rst_cycles", v), 32'(n_rst_hi), 32'd32);
      chk($sformatf("v%0d_rst_after_last_wr", v), 32'(rst_fall > last_wr), 32'd1);
      chk($sformatf("v%0d_err", v), 32'(ERR), 32'd0);
      @(negedge DCLK);
      chk($sformatf("v%0d_ack_one_cycle", v), 32'(ACK), 32'd0);
      chk($sformatf("v%0d_busy_low", v), 32'(BUSY), 32'd0);
    end

    // DRP never answers
    drp_answer = 1'b0;
    start_req(1'b0);
    seq_watch(3000);
    chk("drp_to_latency", 32'(ack_at - first_den), 32'd64);
    chk("drp_to_err", 32'(ERR), 32'd1);
    chk("drp_to_pll_rst", 32'(PLL_RST), 32'd1);
    chk("drp_to_pll_rst_never_low", 32'(rst_fall < 0), 32'd1);
    chk("drp_to_n_den", 32'(n_den), 32'd1);
    @(negedge DCLK);
    drp_answer = 1'b1;
    chk("drp_to_err_sticky", 32'(ERR), 32'd1);
    chk("drp_to_busy_low", 32'(BUSY), 32'd0);

    // LOCKED never rises
    lock_block = 1'b1;
    start_req(1'b1);
    seq_watch(3000);
    chk("lock_to_latency", 32'(ack_at - rst_fall), 32'd1024);
    chk("lock_to_err", 32'(ERR), 32'd2);
    chk("lock_to_pll_rst", 32'(PLL_RST), 32'd1);
    @(negedge DCLK);
    lock_block = 1'b0;
    start_req(1'b1);
    chk("lock_to_err_held_busy", 32'(ERR), 32'd2);
    seq_watch(3000);
    chk("lock_to_err_cleared", 32'(ERR), 32'd0);
    @(negedge DCLK);

    // REQ held high across ACK restarts on the first IDLE cycle
    REQ = 1'b1; REQ_SEL = 1'b0;
    @(negedge DCLK);
    seq_watch(3000);
    @(negedge DCLK);
    chk("req_hold_idle", 32'(BUSY), 32'd0);
    @(negedge DCLK);
    chk("req_hold_restart", 32'(BUSY), 32'd1);
    REQ = 1'b0;
    seq_watch(3000);
    chk("req_hold_second_n_wr", 32'(n_wr), 32'd4);
    @(negedge DCLK);

    // Reset asserted in WR_WAIT of step 2
    start_req(1'b1);
    nw = 0;
    for (int i = 0; i < 300; i++) begin
      if (DEN && DWE) nw++;
      if (nw == 3) break;
      @(negedge DCLK);
    end
    chk("mid_third_write_seen", 32'(nw), 32'd3);
    @(negedge DCLK);
    chk("mid_in_wr_wait", {30'd0, DEN, DWE}, 32'd1);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_pll_rst", 32'(PLL_RST), 32'd1);
    chk("mid_rst_den", 32'(DEN), 32'd0);
    chk("mid_rst_busy", 32'(BUSY), 32'd1);
    chk("mid_rst_dwe", 32'(DWE), 32'd0);
    chk("mid_rst_daddr", 32'(DADDR), 32'd0);
    @(negedge DCLK);
    RST_N = 1'b1;
    seq_watch(3000);
    chk("mid_bringup_den", 32'(n_den), 32'd0);
    chk("mid_bringup_rst_cycles", 32'(n_rst_hi), 32'd16);
    chk("mid_bringup_err", 32'(ERR), 32'd0);
    @(negedge DCLK);
    chk("mid_bringup_busy_low", 32'(BUSY), 32'd0);

    // Lock loss while idle
    chk("lock_lost_before", 32'(LOCK_LOST), 32'd0);
    lock_block = 1'b1;
    repeat (2) @(negedge DCLK);
    lock_block = 1'b0;
`ifdef PLL_RECONFIG_LOCK_MON_EN
    seq_watch(3000);
    chk("lock_lost_set", 32'(LOCK_LOST), 32'd1);
    chk("lock_lost_den", 32'(n_den), 32'd0);
    chk("lock_lost_err", 32'(ERR), 32'd0);
    @(negedge DCLK);
    chk("lock_lost_busy_low", 32'(BUSY), 32'd0);
    chk("lock_lost_sticky", 32'(LOCK_LOST), 32'd1);
`else
    nw = 0;
    for (int i = 0; i < 10; i++) begin
      if (BUSY) nw++;
      @(negedge DCLK);
    end
    chk("lock_drop_ignored_busy", 32'(nw), 32'd0);
    chk("lock_drop_lock_lost", 32'(LOCK_LOST), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
